// File: rtl/tlb_asid_if.sv
// Shared types and the port bundle between the TLB and its client
// (AGU/fetch stage plus page walker and sfence sequencer).

package tlb_asid_pkg;

  // Leaf PTE as reported by the page walker.
  // pgsize: 2 = 4K, 1 = 2M, 0 (or 3) = 1G.
  typedef struct packed {
    logic [63:0] paddr;
    logic [1:0]  pgsize;
    logic        d;
    logic        u;
    logic        x;
    logic        w;
    logic        r;
  } page_walk_rsp_t;

endpackage

interface tlb_asid_if #(
  parameter int ASID_W = 16
);
  import tlb_asid_pkg::*;

  // Translation context
  logic              active;
  logic [1:0]        priv;
  logic              sum;

  // Lookup request / registered response
  logic              req;
  logic [63:0]       va;
  logic [ASID_W-1:0] asid;
  logic              is_store;
  logic              hit;
  logic              fault;
  logic [63:0]       pa;
  logic              dirty;

  // Refill from the page walker
  logic              replace;
  logic [63:0]       replace_va;
  logic [ASID_W-1:0] replace_asid;
  logic              replace_global;
  page_walk_rsp_t    page_walk_rsp;

  // sfence.vma handshake
  logic              flush_req;
  logic              flush_va_valid;
  logic [63:0]       flush_va;
  logic              flush_asid_valid;
  logic [ASID_W-1:0] flush_asid;
  logic              flush_ack;

  modport master (
    output active, priv, sum,
    output req, va, asid, is_store,
    input  hit, fault, pa, dirty,
    output replace, replace_va, replace_asid, replace_global, page_walk_rsp,
    output flush_req, flush_va_valid, flush_va, flush_asid_valid, flush_asid,
    input  flush_ack
  );

  modport slave (
    input  active, priv, sum,
    input  req, va, asid, is_store,
    output hit, fault, pa, dirty,
    input  replace, replace_va, replace_asid, replace_global, page_walk_rsp,
    input  flush_req, flush_va_valid, flush_va, flush_asid_valid, flush_asid,
    output flush_ack
  );

endinterface

// File: rtl/tlb_asid.sv
// Fully-associative Sv39 TLB with ASID-tagged and global entries,
// selective sfence.vma flush, tree-PLRU replacement (invalid-first fill),
// duplicate-free refill and a registered permission-fault check.

module tlb_asid
  import tlb_asid_pkg::*;
#(
  parameter int LG_N   = 3,
  parameter int ASID_W = 16,
  parameter int ISIDE  = 0
) (
  input  logic     clk,
  input  logic     reset,
  tlb_asid_if.slave bus
);

  localparam int N = 1 << LG_N;

  // Entry storage: control (valid) is reset, payload is not
  logic [N-1:0]      ent_vld;
  logic [N-1:0]      ent_g;
  logic [ASID_W-1:0] ent_asid [N];
  logic [26:0]       ent_vpn  [N];
  logic [1:0]        ent_size [N];
  logic [51:0]       ent_ppn  [N];
  logic [N-1:0]      ent_d, ent_u, ent_x, ent_w, ent_r;

  logic [N-2:0]      plru, plru_nxt;

  // Flush request latched for execution in the following cycle
  logic              fl_pend;
  logic              fl_va_vld;
  logic [26:0]       fl_vpn;
  logic              fl_asid_vld;
  logic [ASID_W-1:0] fl_asid;

  // Lookup stage outputs
  logic              hit_p1, fault_p1, dirty_p1;
  logic [63:0]       pa_p1;

  logic [N-1:0]      lk_match, rf_match, fl_kill;
  logic [LG_N-1:0]   lk_idx, rf_idx;
  logic              lk_hit;
  logic              rf_en;
  logic              hit_p0, fault_p0, dirty_p0;
  logic [63:0]       pa_p0;

  // Address bits outside the Sv39 VPN / page offset are not needed here
  logic unused_bits;
  assign unused_bits = ^{bus.replace_va[63:39], bus.replace_va[11:0],
                         bus.flush_va[63:39], bus.flush_va[11:0],
                         bus.page_walk_rsp.paddr[11:0]};

  // VPN compare honouring the entry's page size.
  function automatic logic vtag_eq(input logic [26:0] vpn, input logic [1:0] size,
                                   input logic [26:0] a);
    logic eq;
    case (size)
      2'd2:    eq = (a == vpn);
      2'd1:    eq = (a[26:9] == vpn[26:9]);
      default: eq = (a[26:18] == vpn[26:18]);
    endcase
    return eq;
  endfunction

  // Physical address: PPN bits above the page offset, VA bits inside it.
  function automatic logic [63:0] merge_pa(input logic [51:0] ppn, input logic [1:0] size,
                                           input logic [29:0] off);
    logic [63:0] p;
    case (size)
      2'd2:    p = {ppn, off[11:0]};
      2'd1:    p = {ppn[51:9], off[20:0]};
      default: p = {ppn[51:18], off[29:0]};
    endcase
    return p;
  endfunction

  // Permission violation for a hit entry.
  function automatic logic perm_fault(input logic [1:0] prv, input logic sm,
                                      input logic fetch, input logic store,
                                      input logic d, input logic u, input logic x,
                                      input logic w, input logic r);
    logic f;
    if (fetch)      f = ~x;
    else if (store) f = ~(w & d);
    else            f = ~r;
    if (prv == 2'd0 && !u) f = 1'b1;
    if (prv == 2'd1 && u && (fetch || !sm)) f = 1'b1;
    return f;
  endfunction

  // Lowest set bit index (lowest index wins on multiple matches).
  function automatic logic [LG_N-1:0] first_set(input logic [N-1:0] v);
    logic [LG_N-1:0] r;
    r = '0;
    for (int i = N - 1; i >= 0; i--)
      if (v[i]) r = LG_N'(i);
    return r;
  endfunction

  // Tree PLRU: node k lives in bit k-1; each bit points toward the colder half.
  function automatic logic [N-2:0] plru_touch(input logic [N-2:0] bits,
                                              input logic [LG_N-1:0] idx);
    logic [N-2:0] b;
    int node;
    b = bits;
    node = 1;
    for (int lvl = LG_N - 1; lvl >= 0; lvl--) begin
      b[node-1] = ~idx[lvl];
      node = 2 * node + int'(idx[lvl]);
    end
    return b;
  endfunction

  function automatic logic [LG_N-1:0] plru_victim(input logic [N-2:0] bits);
    int node;
    node = 1;
    for (int lvl = 0; lvl < LG_N; lvl++)
      node = 2 * node + int'(bits[node-1]);
    return LG_N'(node - N);
  endfunction

  // Per-entry match vectors for lookup, refill dedup and flush selection
  always_comb begin
    lk_match = '0;
    rf_match = '0;
    fl_kill  = '0;
    for (int i = 0; i < N; i++) begin
      lk_match[i] = ent_vld[i] & (ent_g[i] | (ent_asid[i] == bus.asid)) &
                    vtag_eq(ent_vpn[i], ent_size[i], bus.va[38:12]);
      rf_match[i] = ent_vld[i] & (ent_g[i] | (ent_asid[i] == bus.replace_asid)) &
                    vtag_eq(ent_vpn[i], ent_size[i], bus.replace_va[38:12]);
      fl_kill[i]  = ent_vld[i] &
                    (~fl_va_vld | vtag_eq(ent_vpn[i], ent_size[i], fl_vpn)) &
                    (~fl_asid_vld | (~ent_g[i] & (ent_asid[i] == fl_asid)));
    end
  end

  // Refill target selection and acceptance (dropped while a flush is in flight)
  always_comb begin
    rf_en = bus.replace & ~bus.flush_req & ~fl_pend;
    if (|rf_match)      rf_idx = first_set(rf_match);
    else if (~&ent_vld) rf_idx = first_set(~ent_vld);
    else                rf_idx = plru_victim(plru);
  end

  // Lookup result computed ahead of the output register
  always_comb begin
    lk_idx   = first_set(lk_match);
    lk_hit   = bus.active & bus.req & (|lk_match);
    hit_p0   = ~bus.active | lk_hit;
    pa_p0    = '0;
    fault_p0 = 1'b0;
    dirty_p0 = 1'b0;
    if (!bus.active) begin
      pa_p0 = bus.va;
    end else if (lk_hit) begin
      pa_p0    = merge_pa(ent_ppn[lk_idx], ent_size[lk_idx], bus.va[29:0]);
      dirty_p0 = ent_d[lk_idx];
      fault_p0 = perm_fault(bus.priv, bus.sum, ISIDE != 0,
                            (ISIDE == 0) & bus.is_store,
                            ent_d[lk_idx], ent_u[lk_idx], ent_x[lk_idx],
                            ent_w[lk_idx], ent_r[lk_idx]);
    end
  end

  // PLRU next state: lookup touch first, refill touch applied on top
  always_comb begin
    plru_nxt = plru;
    if (lk_hit) plru_nxt = plru_touch(plru_nxt, lk_idx);
    if (rf_en)  plru_nxt = plru_touch(plru_nxt, rf_idx);
  end

  // ---- stage p1: registered lookup response ----
  always_ff @(posedge clk) begin
    if (reset) begin
      hit_p1   <= 1'b0;
      fault_p1 <= 1'b0;
      pa_p1    <= '0;
      dirty_p1 <= 1'b0;
    end else begin
      hit_p1   <= hit_p0;
      fault_p1 <= fault_p0;
      pa_p1    <= pa_p0;
      dirty_p1 <= dirty_p0;
    end
  end

  // Valid bits: flush invalidation, else refill install
  always_ff @(posedge clk) begin
    if (reset)        ent_vld <= '0;
    else if (fl_pend) ent_vld <= ent_vld & ~fl_kill;
    else if (rf_en)   ent_vld[rf_idx] <= 1'b1;
  end

  // Entry payload write on accepted refill
  always_ff @(posedge clk) begin
    if (rf_en) begin
      ent_g[rf_idx]    <= bus.replace_global;
      ent_asid[rf_idx] <= bus.replace_asid;
      ent_vpn[rf_idx]  <= bus.replace_va[38:12];
      ent_size[rf_idx] <= bus.page_walk_rsp.pgsize;
      ent_ppn[rf_idx]  <= bus.page_walk_rsp.paddr[63:12];
      ent_d[rf_idx]    <= bus.page_walk_rsp.d;
      ent_u[rf_idx]    <= bus.page_walk_rsp.u;
      ent_x[rf_idx]    <= bus.page_walk_rsp.x;
      ent_w[rf_idx]    <= bus.page_walk_rsp.w;
      ent_r[rf_idx]    <= bus.page_walk_rsp.r;
    end
  end

  // PLRU state register
  always_ff @(posedge clk) begin
    if (reset) plru <= '0;
    else       plru <= plru_nxt;
  end

  // Flush pending flag; a request arriving while pending is merged into it
  always_ff @(posedge clk) begin
    if (reset)              fl_pend <= 1'b0;
    else if (fl_pend)       fl_pend <= 1'b0;
    else if (bus.flush_req) fl_pend <= 1'b1;
  end

  // Flush operands captured with the request that arms the flush
  always_ff @(posedge clk) begin
    if (bus.flush_req && !fl_pend) begin
      fl_va_vld   <= bus.flush_va_valid;
      fl_vpn      <= bus.flush_va[38:12];
      fl_asid_vld <= bus.flush_asid_valid;
      fl_asid     <= bus.flush_asid;
    end
  end

  assign bus.hit       = hit_p1;
  assign bus.fault     = fault_p1;
  assign bus.pa        = pa_p1;
  assign bus.dirty     = dirty_p1;
  // Ack coincides with the invalidation cycle; a reset in that cycle abandons it
  assign bus.flush_ack = fl_pend & ~reset;

endmodule

// File: tb/tb_tlb_asid.sv
// Self-checking bench for tlb_asid: table of lookup vectors plus hand-written
// refill/replacement/flush/reset sequences, checked through a scoreboard queue.

module tb_tlb_asid;
  import tlb_asid_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   errors = 0;
  int   checks = 0;
  int   ack_cnt = 0;

  tlb_asid_if #(.ASID_W(16)) bus ();

  tlb_asid #(.LG_N(3), .ASID_W(16), .ISIDE(0)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (bus.flush_ack === 1'b1) ack_cnt++;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, actual=timeout required=finish");
    $fatal(1);
  end

  typedef struct {
    logic [63:0] va;
    logic [15:0] asid;
    logic        st;
    logic [1:0]  priv;
    logic        sum;
    logic        act;
    logic        e_hit;
    logic        e_fault;
    logic [63:0] e_pa;
    logic        e_dirty;
    string       name;
  } vec_t;

  typedef struct {
    logic        hit;
    logic        fault;
    logic [63:0] pa;
    logic        dirty;
    string       name;
  } exp_t;

  exp_t sb[$];
  vec_t tbl[15];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic check_out();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("FAIL scoreboard: actual=empty required=entry");
      return;
    end
    e = sb.pop_front();
    if (bus.hit !== e.hit || bus.fault !== e.fault ||
        (e.hit && (bus.pa !== e.pa || bus.dirty !== e.dirty))) begin
      errors++;
      $display("FAIL %s: actual hit=%b fault=%b pa=%h dirty=%b required hit=%b fault=%b pa=%h dirty=%b",
               e.name, bus.hit, bus.fault, bus.pa, bus.dirty, e.hit, e.fault, e.pa, e.dirty);
    end
  endtask

  task automatic run_vec(input vec_t v);
    exp_t e;
    bus.req = 1'b1; bus.va = v.va; bus.asid = v.asid; bus.is_store = v.st;
    bus.priv = v.priv; bus.sum = v.sum; bus.active = v.act;
    e.hit = v.e_hit; e.fault = v.e_fault; e.pa = v.e_pa; e.dirty = v.e_dirty; e.name = v.name;
    sb.push_back(e);
    step();
    bus.req = 1'b0; bus.active = 1'b1; bus.priv = 2'd1; bus.sum = 1'b0; bus.is_store = 1'b0;
    check_out();
  endtask

  // Plain S-mode load with d=0 entries
  task automatic lk(input logic [63:0] va, input logic [15:0] asid, input logic e_hit,
                    input logic [63:0] e_pa, input string name);
    vec_t v;
    v = '{va, asid, 1'b0, 2'd1, 1'b0, 1'b1, e_hit, 1'b0, e_pa, 1'b0, name};
    run_vec(v);
  endtask

  // perm = {d,u,x,w,r}
  task automatic set_rsp(input logic [63:0] va, input logic [15:0] asid, input logic g,
                         input logic [1:0] sz, input logic [63:0] paddr, input logic [4:0] perm);
    page_walk_rsp_t pw;
    pw.paddr = paddr; pw.pgsize = sz;
    {pw.d, pw.u, pw.x, pw.w, pw.r} = perm;
    bus.replace_va = va; bus.replace_asid = asid; bus.replace_global = g;
    bus.page_walk_rsp = pw;
  endtask

  task automatic install(input logic [63:0] va, input logic [15:0] asid, input logic g,
                         input logic [1:0] sz, input logic [63:0] paddr, input logic [4:0] perm);
    set_rsp(va, asid, g, sz, paddr, perm);
    bus.replace = 1'b1;
    step();
    bus.replace = 1'b0;
  endtask

  task automatic set_flush(input logic vv, input logic [63:0] fva, input logic av,
                           input logic [15:0] fas);
    bus.flush_va_valid = vv; bus.flush_va = fva;
    bus.flush_asid_valid = av; bus.flush_asid = fas;
    bus.flush_req = 1'b1;
  endtask

  // One flush: ack must be high in the cycle after the request, low afterwards
  task automatic do_flush(input logic vv, input logic [63:0] fva, input logic av,
                          input logic [15:0] fas, input string name);
    int a0;
    a0 = ack_cnt;
    set_flush(vv, fva, av, fas);
    chk({name, " ack low in req cycle"}, 64'(bus.flush_ack), 64'd0);
    step();
    bus.flush_req = 1'b0;
    chk({name, " ack pulse"}, 64'(bus.flush_ack), 64'd1);
    step();
    chk({name, " ack drop"}, 64'(bus.flush_ack), 64'd0);
    step();
    chk({name, " ack count"}, 64'(ack_cnt - a0), 64'd1);
  endtask

  initial begin
    int a0;
    logic [63:0] pv;

    // S-mode = 1, U-mode = 0
    tbl[0]  = '{64'h4000_1234, 16'd5, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h8020_0234, 1'b0, "A load asid5"};
    tbl[1]  = '{64'h4000_1234, 16'd6, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, "A asid6 miss"};
    tbl[2]  = '{64'h4000_1234, 16'd5, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8020_0234, 1'b0, "A store no W"};
    tbl[3]  = '{64'h0020_3456, 16'd5, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h8040_3456, 1'b0, "B 2M load"};
    tbl[4]  = '{64'h0020_3456, 16'd5, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8040_3456, 1'b0, "B store D=0"};
    tbl[5]  = '{64'h0000_7abc, 16'd5, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h9000_0abc, 1'b1, "C S-load U sum0"};
    tbl[6]  = '{64'h0000_7abc, 16'd5, 1'b0, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h9000_0abc, 1'b1, "C S-load U sum1"};
    tbl[7]  = '{64'h0000_7abc, 16'd5, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b0, 64'h9000_0abc, 1'b1, "C U-load"};
    tbl[8]  = '{64'h4000_1234, 16'd5, 1'b0, 2'd0, 1'b0, 1'b1, 1'b1, 1'b1, 64'h8020_0234, 1'b0, "A U-load no U"};
    tbl[9]  = '{64'h0_c123_4567, 16'd6, 1'b0, 2'd1, 1'b0, 1'b1, 1'b1, 1'b0, 64'h1_4123_4567, 1'b0, "G 1G global"};
    tbl[10] = '{64'h0_c123_4567, 16'd6, 1'b1, 2'd1, 1'b0, 1'b1, 1'b1, 1'b1, 64'h1_4123_4567, 1'b0, "G store no W"};
    tbl[11] = '{64'h1234_5678, 16'd5, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 64'h1234_5678, 1'b0, "bypass"};
    tbl[12] = '{64'h0000_7abc, 16'd5, 1'b1, 2'd1, 1'b1, 1'b1, 1'b1, 1'b0, 64'h9000_0abc, 1'b1, "C S-store sum1"};
    tbl[13] = '{64'h4000_2000, 16'd5, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, "neighbour miss"};
    tbl[14] = '{64'h0020_3456, 16'd9, 1'b0, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0, 64'h0, 1'b0, "B asid9 miss"};

    bus.active = 1'b1; bus.priv = 2'd1; bus.sum = 1'b0;
    bus.req = 1'b0; bus.va = '0; bus.asid = '0; bus.is_store = 1'b0;
    bus.replace = 1'b0; bus.flush_req = 1'b0;
    set_rsp('0, '0, 1'b0, 2'd2, '0, 5'b0);
    bus.flush_va_valid = 1'b0; bus.flush_va = '0;
    bus.flush_asid_valid = 1'b0; bus.flush_asid = '0;

    repeat (3) step();
    reset = 1'b0;
    chk("reset hit", 64'(bus.hit), 64'd0);
    chk("reset fault", 64'(bus.fault), 64'd0);
    chk("reset pa", bus.pa, 64'd0);
    chk("reset dirty", 64'(bus.dirty), 64'd0);
    chk("reset flush_ack", 64'(bus.flush_ack), 64'd0);

    lk(64'h4000_1234, 16'd5, 1'b0, 64'h0, "empty miss");
    tbl[11].va = 64'h4000_1234; tbl[11].e_pa = 64'h4000_1234;
    run_vec(tbl[11]);
    tbl[11].va = 64'h1234_5678; tbl[11].e_pa = 64'h1234_5678;

    // A, B, C, G land in entries 0..3
    install(64'h4000_1000, 16'd5, 1'b0, 2'd2, 64'h8020_0000, 5'b00001);
    install(64'h0020_0000, 16'd5, 1'b0, 2'd1, 64'h8040_0000, 5'b00011);
    install(64'h0000_7000, 16'd5, 1'b0, 2'd2, 64'h9000_0000, 5'b11011);
    install(64'h0_c000_0000, 16'd7, 1'b1, 2'd0, 64'h1_4000_0000, 5'b00101);

    foreach (tbl[i]) run_vec(tbl[i]);

    // Selective flushes
    install(64'h4000_1000, 16'd6, 1'b0, 2'd2, 64'hA000_0000, 5'b00001);
    lk(64'h4000_1234, 16'd6, 1'b1, 64'hA000_0234, "D asid6 hit");
    do_flush(1'b0, 64'h0, 1'b1, 16'd5, "flush asid5");
    lk(64'h4000_1234, 16'd5, 1'b0, 64'h0, "A flushed");
    lk(64'h0020_3456, 16'd5, 1'b0, 64'h0, "B flushed");
    lk(64'h0000_7abc, 16'd5, 1'b0, 64'h0, "C flushed");
    lk(64'h0_c123_4567, 16'd5, 1'b1, 64'h1_4123_4567, "G kept");
    lk(64'h4000_1234, 16'd6, 1'b1, 64'hA000_0234, "D kept");
    do_flush(1'b1, 64'h4000_1000, 1'b0, 16'd0, "flush va");
    lk(64'h4000_1234, 16'd6, 1'b0, 64'h0, "D va-flushed");
    lk(64'h0_c123_4567, 16'd6, 1'b1, 64'h1_4123_4567, "G survives va flush");

    // Replace coincident with flush_req is dropped
    set_rsp(64'h6000_0000, 16'd5, 1'b0, 2'd2, 64'hB000_0000, 5'b00001);
    bus.replace = 1'b1;
    set_flush(1'b0, 64'h0, 1'b1, 16'h33);
    step();
    bus.replace = 1'b0; bus.flush_req = 1'b0;
    step();
    lk(64'h6000_0010, 16'd5, 1'b0, 64'h0, "replace during flush dropped");

    // Back-to-back requests merge into one ack
    a0 = ack_cnt;
    set_flush(1'b0, 64'h0, 1'b1, 16'h33);
    step();
    chk("merge ack pulse", 64'(bus.flush_ack), 64'd1);
    step();
    bus.flush_req = 1'b0;
    chk("merge ack drop", 64'(bus.flush_ack), 64'd0);
    repeat (2) step();
    chk("merge ack count", 64'(ack_cnt - a0), 64'd1);
    lk(64'h0_c123_4567, 16'd6, 1'b1, 64'h1_4123_4567, "G after merged flush");

    do_flush(1'b0, 64'h0, 1'b0, 16'd0, "flush all");
    lk(64'h0_c123_4567, 16'd6, 1'b0, 64'h0, "G after flush all");

    // Reset while a flush is pending
    install(64'h7000_0000, 16'd5, 1'b0, 2'd2, 64'hC000_0000, 5'b00001);
    lk(64'h7000_0040, 16'd5, 1'b1, 64'hC000_0040, "F hit");
    a0 = ack_cnt;
    set_flush(1'b0, 64'h0, 1'b1, 16'h33);
    step();
    bus.flush_req = 1'b0;
    reset = 1'b1;
    #1;
    chk("ack under reset", 64'(bus.flush_ack), 64'd0);
    step();
    reset = 1'b0;
    repeat (2) step();
    chk("no ack after reset", 64'(ack_cnt - a0), 64'd0);
    lk(64'h7000_0040, 16'd5, 1'b0, 64'h0, "F gone after reset");

    // Fill N+1 pages with entry 0 kept hot; PLRU then evicts entry 4
    for (int k = 0; k < 8; k++) begin
      install(64'h1000_0000 + 64'(k) * 64'h1000, 16'd9, 1'b0, 2'd2,
              64'h2000_0000 + 64'(k) * 64'h1000, 5'b00001);
      lk(64'h1000_0008, 16'd9, 1'b1, 64'h2000_0008, "P0 touch");
    end
    install(64'h1000_8000, 16'd9, 1'b0, 2'd2, 64'h2000_8000, 5'b00001);
    lk(64'h1000_0008, 16'd9, 1'b1, 64'h2000_0008, "P0 survives");
    lk(64'h1000_8008, 16'd9, 1'b1, 64'h2000_8008, "P8 installed");
    lk(64'h1000_4008, 16'd9, 1'b0, 64'h0, "P4 evicted");

    // Overwrite of an existing page stays in place
    install(64'h1000_2000, 16'd9, 1'b0, 2'd2, 64'h3000_0000, 5'b00001);
    lk(64'h1000_2010, 16'd9, 1'b1, 64'h3000_0010, "P2 overwritten");
    for (int k = 0; k < 9; k++) begin
      if (k != 2 && k != 4) begin
        pv = 64'h2000_0000 + 64'(k) * 64'h1000 + 64'h10;
        lk(64'h1000_0010 + 64'(k) * 64'h1000, 16'd9, 1'b1, pv, "others intact");
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
